// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encodings and constants for the sequential divider
package seq_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/div_sub_step.sv
// div_sub_step: trial subtraction a - b computed as a + ~b + 1 with borrow detect
module div_sub_step #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);
  assign {no_borrow, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider, one quotient bit per cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, divisor, a_mag, b_mag;
  logic sign_a, sign_b, div_zero, ovf;
  logic [WIDTH:0] trial;
  logic no_borrow, take;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign take = no_borrow & ~trial[WIDTH];
  div_sub_step #(.WIDTH(WIDTH + 1)) u_step (
    .a        ({rem, dvd[WIDTH-1]}),
    .b        ({1'b0, divisor}),
    .diff     (trial),
    .no_borrow(no_borrow)
  );
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= state_nx;
  // next state: fixed-length run, no early exit
  always_comb begin
    state_nx = (state == S_IDLE) ? (ctrl_DIV ? S_RUN : S_IDLE) :
               (state == S_RUN)  ? ((cnt == CNT_W'(WIDTH - 1)) ? S_FIN : S_RUN) : S_IDLE;
  end
  // busy covers every non-idle cycle
  always_comb begin
    busy = state != S_IDLE;
  end
  // operand capture, shift-subtract iteration and signed result fix-up
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt            <= '0;
      rem            <= '0;
      dvd            <= '0;
      divisor        <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      div_zero       <= 1'b0;
      ovf            <= 1'b0;
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        S_IDLE: if (ctrl_DIV) begin
          dvd      <= a_mag;
          divisor  <= b_mag;
          rem      <= '0;
          cnt      <= '0;
          sign_a   <= data_operandA[WIDTH-1];
          sign_b   <= data_operandB[WIDTH-1];
          div_zero <= data_operandB == '0;
          ovf      <= (data_operandA == INT_MIN) && (&data_operandB);
        end
        S_RUN: begin
          rem <= take ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
          dvd <= {dvd[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
        end
        S_FIN: begin
          data_resultRDY <= 1'b1;
          data_exception <= div_zero | ovf;
          data_quotient  <= div_zero ? '0 : ovf ? INT_MIN : (sign_a ^ sign_b) ? -dvd : dvd;
          data_remainder <= (div_zero | ovf) ? '0 : sign_a ? -rem : rem;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_quotient, data_remainder;
  logic        data_exception, data_resultRDY, busy;
  int checks = 0;
  int failures = 0;

  seq_divider dut (
    .clock         (clock),
    .resetn        (resetn),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_quotient (data_quotient),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 0; r = 0; e = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; e = 1;
    end else begin
      q = sa / sb; r = sa % sb; e = 0;
    end
  endfunction

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic ee;
    model(a, b, eq, er, ee);
    check({tag, ".q"}, data_quotient, eq);
    check({tag, ".r"}, data_remainder, er);
    check({tag, ".exc"}, data_exception, ee);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit repulse, input string tag);
    int lat, busy_low;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    busy_low = 0;
    while (!data_resultRDY && lat < 60) begin
      if (repulse && lat == 9) begin
        ctrl_DIV = 1'b1;
        data_operandA = 9;
        data_operandB = 3;
      end else ctrl_DIV = 1'b0;
      if (!busy) busy_low++;
      @(posedge clock);
      #1;
      lat++;
    end
    ctrl_DIV = 1'b0;
    check({tag, ".lat"}, lat, 33);
    check({tag, ".busy_run"}, busy_low, 0);
    check({tag, ".busy_end"}, busy, 0);
    check_result(tag, a, b);
    @(posedge clock);
    #1;
    check({tag, ".rdy_pulse"}, data_resultRDY, 0);
  endtask

  initial begin
    int lat, rdy_seen;
    logic [31:0] a, b;
    #1;
    check("rst.q", data_quotient, 0);
    check("rst.r", data_remainder, 0);
    check("rst.exc", data_exception, 0);
    check("rst.rdy", data_resultRDY, 0);
    check("rst.busy", busy, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    run_div(100, 7, 0, "d100_7");
    run_div(-100, 7, 0, "dm100_7");
    run_div(100, -7, 0, "d100_m7");
    run_div(5, 0, 0, "div0");
    run_div(20, 4, 0, "d20_4");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf");
    run_div(32'h8000_0000, 2, 0, "min_2");
    run_div(100, 7, 1, "repulse");
    run_div(9, 3, 0, "d9_3");

    @(negedge clock);
    data_operandA = 20;
    data_operandB = 4;
    ctrl_DIV = 1'b1;
    lat = 0;
    while (!data_resultRDY && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("hold1.lat", lat, 34);
    check_result("hold1", 20, 4);
    data_operandA = 9;
    data_operandB = -3;
    lat = 0;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    lat = 1;
    check("hold2.busy", busy, 1);
    while (!data_resultRDY && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("hold2.lat", lat, 34);
    check_result("hold2", 9, -3);

    @(negedge clock);
    data_operandA = 100;
    data_operandB = 7;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("arst.q", data_quotient, 0);
    check("arst.r", data_remainder, 0);
    check("arst.exc", data_exception, 0);
    check("arst.busy", busy, 0);
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    check("arst.quiet", rdy_seen, 0);
    resetn = 1'b1;
    run_div(100, 7, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 20);
        1: b = -$urandom_range(1, 20);
        2: b = 0;
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      if (i == 7) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_div(a, b, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
